// File: rtl/pwm_capture_if.sv
// PWM capture signal bundle: the measured PWM input and the per-period
// sample outputs (strobe, high time, period, stuck flag).
// master: the side that drives the PWM pin and consumes samples.
// slave : the capture block itself.
interface pwm_capture_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 pin_in;
  logic                 o_ce;
  logic [CNT_WIDTH-1:0] o_high;
  logic [CNT_WIDTH-1:0] o_period;
  logic                 o_stuck;

  modport master (
    output pin_in,
    input  o_ce,
    input  o_high,
    input  o_period,
    input  o_stuck
  );

  modport slave (
    input  pin_in,
    output o_ce,
    output o_high,
    output o_period,
    output o_stuck
  );
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of an asynchronous PWM input
// in clk cycles and emits one sample per period with a one-cycle o_ce.
// Optional glitch filter: define PWM_CAPTURE_GLITCH_FILTER_EN to require
// FILT_LEN cycles of stable synchronized level before an input change counts.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | after reset; waiting for the first rise (partial period, no report)
// S_MEAS  | measuring; each rise reports the completed period
// S_STUCK | no rise for TIMEOUT cycles; repeat timeout report every TIMEOUT
module pwm_capture #(
  parameter int CNT_WIDTH = 16,
  parameter int TIMEOUT   = 1024,
  parameter int FILT_LEN  = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  pwm_capture_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MEAS  = 2'd1,
    S_STUCK = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] TO_VAL  = CNT_WIDTH'(TIMEOUT);

  // Reject parameter sets the timeout/filter logic cannot honour.
  if (TIMEOUT < 2 || FILT_LEN < 1) begin : g_param_chk
    $error("pwm_capture: TIMEOUT must be >= 2 and FILT_LEN >= 1");
  end

  state_t               state, state_nxt;
  logic                 sync_q1, s_pin, s_lvl, s_prev;
  logic                 rise, tmo;
  logic                 rpt_meas, rpt_stuck, clr_stuck;
  logic [CNT_WIDTH-1:0] per_cnt, hi_cnt;
  logic                 ce_q, stuck_q;
  logic [CNT_WIDTH-1:0] high_q, period_q;

  // Two-flop synchronizer for the asynchronous PWM pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      s_pin   <= 1'b0;
    end else begin
      sync_q1 <= bus.pin_in;
      s_pin   <= sync_q1;
    end
  end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [FW-1:0] STAB_LAST = FW'(FILT_LEN - 1);

  logic [FW-1:0] stab_cnt;
  logic          filt;

  // Filtered level follows s_pin only after FILT_LEN consecutive cycles at the new level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stab_cnt <= '0;
      filt     <= 1'b0;
    end else if (s_pin == filt) begin
      stab_cnt <= '0;
    end else if (stab_cnt == STAB_LAST) begin
      filt     <= s_pin;
      stab_cnt <= '0;
    end else begin
      stab_cnt <= stab_cnt + FW'(1);
    end
  end

  assign s_lvl = filt;
`else
  assign s_lvl = s_pin;
`endif

  // Edge history for rising-edge detection on the conditioned level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s_prev <= 1'b0;
    else        s_prev <= s_lvl;
  end

  assign rise = s_lvl & ~s_prev;
  assign tmo  = (per_cnt == TO_VAL);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state and report decisions; a rise always wins over a timeout.
  always_comb begin
    state_nxt = state;
    rpt_meas  = 1'b0;
    rpt_stuck = 1'b0;
    clr_stuck = 1'b0;
    case (state)
      S_IDLE: begin
        if (rise) state_nxt = S_MEAS;
      end
      S_MEAS: begin
        if (rise) begin
          rpt_meas = 1'b1;
        end else if (tmo) begin
          rpt_stuck = 1'b1;
          state_nxt = S_STUCK;
        end
      end
      S_STUCK: begin
        if (rise) begin
          clr_stuck = 1'b1;
          state_nxt = S_MEAS;
        end else if (tmo) begin
          rpt_stuck = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Period and high-time counters; restart on rise, rearm on timeout, else saturate-count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
    end else if (rise) begin
      per_cnt <= CNT_WIDTH'(1);
      hi_cnt  <= CNT_WIDTH'(1);
    end else if (rpt_stuck) begin
      per_cnt <= CNT_WIDTH'(1);
      hi_cnt  <= CNT_WIDTH'(s_lvl);
    end else begin
      if (per_cnt != CNT_MAX)           per_cnt <= per_cnt + CNT_WIDTH'(1);
      if (s_lvl && (hi_cnt != CNT_MAX)) hi_cnt  <= hi_cnt + CNT_WIDTH'(1);
    end
  end

  // Registered sample outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_q     <= 1'b0;
      high_q   <= '0;
      period_q <= '0;
      stuck_q  <= 1'b0;
    end else begin
      ce_q <= rpt_meas | rpt_stuck;
      if (rpt_meas) begin
        high_q   <= hi_cnt;
        period_q <= per_cnt;
        stuck_q  <= 1'b0;
      end else if (rpt_stuck) begin
        high_q   <= s_lvl ? TO_VAL : '0;
        period_q <= TO_VAL;
        stuck_q  <= 1'b1;
      end else if (clr_stuck) begin
        stuck_q  <= 1'b0;
      end
    end
  end

  assign bus.o_ce     = ce_q;
  assign bus.o_high   = high_q;
  assign bus.o_period = period_q;
  assign bus.o_stuck  = stuck_q;

endmodule
